// File: rtl/bip_param_core_if.sv
// Program-memory bus between the BIP core (master) and its synchronous instruction ROM (slave).
interface bip_param_core_if #(
   parameter int unsigned PC_W    = 11,
   parameter int unsigned INSTR_W = 16
) ();
   logic [PC_W-1:0]    prog_addr;
   logic [INSTR_W-1:0] prog_data;

   modport master (output prog_addr, input prog_data);
   modport slave  (input prog_addr, output prog_data);
endinterface

// File: rtl/bip_param_core.sv
// Parameterised accumulator-based BIP core: two-cycle FETCH/EXEC sequencing, internal data memory.
// Optional macro BIP_OVERFLOW_FLAG_EN adds a sticky signed-overflow output.
module bip_param_core #(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned OPCODE_W   = 5,
   parameter int unsigned OPERAND_W  = 11,
   parameter int unsigned PC_W       = 11,
   parameter int unsigned DMEM_DEPTH = 1024,
   parameter int unsigned COUNT_W    = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   bip_param_core_if.master   prog_if,
   output logic [DATA_W-1:0]  accumulator,
   output logic [COUNT_W-1:0] inst_count,
`ifdef BIP_OVERFLOW_FLAG_EN
   output logic               overflow,
`endif
   output logic               done
);

   localparam int unsigned IdxW = $clog2(DMEM_DEPTH);

   localparam logic [OPCODE_W-1:0] OpHlt  = OPCODE_W'(0);
   localparam logic [OPCODE_W-1:0] OpSto  = OPCODE_W'(1);
   localparam logic [OPCODE_W-1:0] OpLd   = OPCODE_W'(2);
   localparam logic [OPCODE_W-1:0] OpLdi  = OPCODE_W'(3);
   localparam logic [OPCODE_W-1:0] OpAdd  = OPCODE_W'(4);
   localparam logic [OPCODE_W-1:0] OpAddi = OPCODE_W'(5);
   localparam logic [OPCODE_W-1:0] OpSub  = OPCODE_W'(6);
   localparam logic [OPCODE_W-1:0] OpSubi = OPCODE_W'(7);

   typedef enum logic [1:0] {StFetch, StExec, StHalt} state_e;

   state_e             state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [DATA_W-1:0]  acc_q, acc_d;
   logic [COUNT_W-1:0] cnt_q, cnt_d;
   logic               done_q, done_d;
   logic               dmem_we;
   logic [DATA_W-1:0]  dmem [DMEM_DEPTH];

   logic [OPCODE_W-1:0]  opcode;
   logic [OPERAND_W-1:0] operand;
   logic [DATA_W-1:0]    imm, mem_rd, rhs, sum, diff;
   logic [IdxW-1:0]      mem_idx;

   assign {opcode, operand} = prog_if.prog_data;
   assign mem_idx           = operand[IdxW-1:0];
   assign mem_rd            = dmem[mem_idx];

   if (OPERAND_W < DATA_W) begin : g_imm_sext
      assign imm = {{(DATA_W - OPERAND_W){operand[OPERAND_W-1]}}, operand};
   end else begin : g_imm_trunc
      assign imm = operand[DATA_W-1:0];
   end

   assign rhs  = (opcode == OpAddi || opcode == OpSubi) ? imm : mem_rd;
   assign sum  = acc_q + rhs;
   assign diff = acc_q - rhs;

`ifdef BIP_OVERFLOW_FLAG_EN
   logic ovf_q, ovf_d, add_ovf, sub_ovf;
   assign add_ovf = (acc_q[DATA_W-1] == rhs[DATA_W-1]) && (sum[DATA_W-1] != acc_q[DATA_W-1]);
   assign sub_ovf = (acc_q[DATA_W-1] != rhs[DATA_W-1]) && (diff[DATA_W-1] != acc_q[DATA_W-1]);
   assign overflow = ovf_q;
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
      dmem_we = 1'b0;
`ifdef BIP_OVERFLOW_FLAG_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         StFetch: if (en) state_d = StExec;
         StExec: begin
            if (en) begin
               if (opcode == OpHlt) begin
                  state_d = StHalt;
                  done_d  = 1'b1;
               end else begin
                  state_d = StFetch;
                  pc_d    = pc_q + PC_W'(1);
                  cnt_d   = cnt_q + COUNT_W'(1);
                  case (opcode)
                     OpSto:  dmem_we = rst;  // reset cancels an in-flight store
                     OpLd:   acc_d = mem_rd;
                     OpLdi:  acc_d = imm;
                     OpAdd, OpAddi: begin
                        acc_d = sum;
`ifdef BIP_OVERFLOW_FLAG_EN
                        ovf_d = ovf_q | add_ovf;
`endif
                     end
                     OpSub, OpSubi: begin
                        acc_d = diff;
`ifdef BIP_OVERFLOW_FLAG_EN
                        ovf_d = ovf_q | sub_ovf;
`endif
                     end
                     default: ;
                  endcase
               end
            end
         end
         StHalt: ;
         default: state_d = StFetch;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StFetch;
         pc_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
`ifdef BIP_OVERFLOW_FLAG_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
`ifdef BIP_OVERFLOW_FLAG_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   // Data memory is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (dmem_we) dmem[mem_idx] <= acc_q;
   end

   assign prog_if.prog_addr = pc_q;
   assign accumulator       = acc_q;
   assign inst_count        = cnt_q;
   assign done              = done_q;

endmodule

// File: tb/tb_bip_param_core.sv
// Scoreboard bench for bip_param_core: directed programs, a retire monitor pops expected results.
// Overflow checks are compiled in when BIP_OVERFLOW_FLAG_EN is defined.
module tb_bip_param_core;

   localparam int unsigned DataW  = 16;
   localparam int unsigned OpcW   = 5;
   localparam int unsigned OprW   = 11;
   localparam int unsigned PcW    = 11;
   localparam int unsigned CntW   = 8;
   localparam int unsigned InstrW = OpcW + OprW;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic en  = 1'b0;
   logic [DataW-1:0] accumulator;
   logic [CntW-1:0]  inst_count;
   logic             done;
`ifdef BIP_OVERFLOW_FLAG_EN
   logic             overflow;
`endif

   bip_param_core_if #(.PC_W(PcW), .INSTR_W(InstrW)) prog_if ();

   bip_param_core #(
      .DATA_W(DataW), .OPCODE_W(OpcW), .OPERAND_W(OprW),
      .PC_W(PcW), .DMEM_DEPTH(1024), .COUNT_W(CntW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .prog_if(prog_if),
      .accumulator(accumulator),
      .inst_count(inst_count),
`ifdef BIP_OVERFLOW_FLAG_EN
      .overflow(overflow),
`endif
      .done(done)
   );

   always #5 clk = ~clk;

   // Synchronous ROM; rom_rand replaces its output with noise.
   logic [InstrW-1:0] rom [2**PcW];
   bit rom_rand = 1'b0;
   always @(posedge clk) begin
      if (rom_rand) prog_if.prog_data <= InstrW'($urandom);
      else          prog_if.prog_data <= rom[prog_if.prog_addr];
   end

   typedef struct packed {
      logic [DataW-1:0] acc;
      logic [CntW-1:0]  cnt;
      logic             dn;
      logic             ovf;
   } exp_t;

   exp_t exp_q[$];
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
      end
   endtask

   task automatic push_exp(input logic [DataW-1:0] a, input logic [CntW-1:0] c,
                           input logic d, input logic o);
      exp_t e;
      e.acc = a; e.cnt = c; e.dn = d; e.ovf = o;
      exp_q.push_back(e);
   endtask

   // Retire monitor: an instruction retires when inst_count moves or done rises.
   bit             mon_en = 1'b0;
   logic [CntW-1:0] last_cnt = '0;
   logic            last_done = 1'b0;
   int              cyc = 0;
   int              done_cyc = -1;

   always @(posedge clk) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      exp_t e;
      if (mon_en && ((inst_count != last_cnt) || (done && !last_done))) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_unexpected: got acc=0x%0h cnt=%0d done=%0b, expected no retire",
                     accumulator, inst_count, done);
         end else begin
            e = exp_q.pop_front();
            check("sb_acc", 32'(accumulator), 32'(e.acc));
            check("sb_cnt", 32'(inst_count), 32'(e.cnt));
            check("sb_done", 32'(done), 32'(e.dn));
`ifdef BIP_OVERFLOW_FLAG_EN
            check("sb_ovf", 32'(overflow), 32'(e.ovf));
`endif
         end
      end
      if (mon_en && done && !last_done) done_cyc = cyc;
      last_cnt  = inst_count;
      last_done = done;
   end

   function automatic logic [InstrW-1:0] enc(input logic [OpcW-1:0] op,
                                             input logic [OprW-1:0] opr);
      return {op, opr};
   endfunction

   task automatic step(input logic en_v);
      en = en_v;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      mon_en = 1'b0;
      exp_q.delete();
      rst = 1'b0;
      step(1'b1);
      check("rst_acc", 32'(accumulator), 32'h0);
      check("rst_cnt", 32'(inst_count), 32'h0);
      check("rst_addr", 32'(prog_if.prog_addr), 32'h0);
      check("rst_done", 32'(done), 32'h0);
`ifdef BIP_OVERFLOW_FLAG_EN
      check("rst_ovf", 32'(overflow), 32'h0);
`endif
      step(1'b1);
      rst      = 1'b1;
      mon_en   = 1'b1;
      done_cyc = -1;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 2**PcW; i++) rom[i] = '0;
   endtask

   task automatic load_prog_a();
      clear_rom();
      rom[0] = enc(5'd3, 11'd5);
      rom[1] = enc(5'd5, 11'd3);
      rom[2] = enc(5'd1, 11'd0);
      rom[3] = enc(5'd7, 11'd10);
      rom[4] = enc(5'd4, 11'd0);
      rom[5] = enc(5'd0, 11'd0);
   endtask

   task automatic push_prog_a();
      push_exp(16'h0005, 8'd1, 1'b0, 1'b0);
      push_exp(16'h0008, 8'd2, 1'b0, 1'b0);
      push_exp(16'h0008, 8'd3, 1'b0, 1'b0);
      push_exp(16'hFFFE, 8'd4, 1'b0, 1'b0);
      push_exp(16'h0006, 8'd5, 1'b0, 1'b0);
      push_exp(16'h0006, 8'd5, 1'b1, 1'b0);
   endtask

   // Bench tracks FETCH/EXEC by counting; stalls land on the EXEC of the first five instructions.
   task automatic run_prog(input bit stall, input int max_instr, input int want_cyc,
                           input string tag);
      int i = 0;
      while (!done && i < max_instr) begin
         step(1'b1);
         if (stall && i < 5) repeat (3) step(1'b0);
         step(1'b1);
         i++;
      end
      @(negedge clk);
      #1;
      check({tag, "_done"}, 32'(done), 32'h1);
      check({tag, "_done_cycle"}, 32'(done_cyc), 32'(want_cyc));
      check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Nominal program.
      load_prog_a();
      apply_reset();
      push_prog_a();
      run_prog(1'b0, 10, 12, "prog_a");

      // After HLT, en and the ROM output are noise; nothing may move.
      rom_rand = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step(1'($urandom));
         check("halt_acc", 32'(accumulator), 32'h6);
         check("halt_cnt", 32'(inst_count), 32'h5);
         check("halt_done", 32'(done), 32'h1);
         check("halt_addr", 32'(prog_if.prog_addr), 32'h5);
      end
      rom_rand = 1'b0;

      // Same program with 3 stall cycles in each non-HLT EXEC.
      apply_reset();
      push_prog_a();
      run_prog(1'b1, 10, 12 + 15, "stall");

      // Reset during the EXEC of ADDI 3, then rerun.
      apply_reset();
      push_prog_a();
      step(1'b1);
      step(1'b1);
      step(1'b1);
      apply_reset();
      push_prog_a();
      run_prog(1'b0, 10, 12, "rerun");

      // 256 NOPs wrap the 8-bit counter; pc reaches 256.
      clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = enc(5'd8, 11'd0);
      apply_reset();
      for (int i = 1; i <= 256; i++) push_exp(16'h0, CntW'(i), 1'b0, 1'b0);
      push_exp(16'h0, 8'd0, 1'b1, 1'b0);
      run_prog(1'b0, 300, 514, "nop");
      check("nop_pc", 32'(prog_if.prog_addr), 32'd256);
      check("nop_cnt", 32'(inst_count), 32'd0);

`ifdef BIP_OVERFLOW_FLAG_EN
      begin
         logic [DataW-1:0] a;
         clear_rom();
         rom[0] = enc(5'd3, 11'd1023);
         rom[1] = enc(5'd1, 11'd1);
         rom[2] = enc(5'd2, 11'd1);
         for (int i = 3; i < 35; i++) rom[i] = enc(5'd4, 11'd1);
         rom[35] = enc(5'd7, 11'd1);
         apply_reset();
         push_exp(16'd1023, 8'd1, 1'b0, 1'b0);
         push_exp(16'd1023, 8'd2, 1'b0, 1'b0);
         push_exp(16'd1023, 8'd3, 1'b0, 1'b0);
         for (int k = 1; k <= 32; k++) begin
            a = DataW'(1023 * (k + 1));
            push_exp(a, CntW'(3 + k), 1'b0, (k == 32));
         end
         push_exp(16'd33758, 8'd36, 1'b0, 1'b1);
         push_exp(16'd33758, 8'd36, 1'b1, 1'b1);
         run_prog(1'b0, 60, 74, "ovf");
         check("ovf_sticky", 32'(overflow), 32'h1);
      end
`endif

      check("final_sb_empty", 32'(exp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bip_param_core.md
BIP_PARAM_CORE -- requirements
Module: bip_param_core

Interface
REQ-001 Parameter DATA_W, default 16, accumulator and data-memory word width.
REQ-002 Parameter OPCODE_W, default 5, opcode field width.
REQ-003 Parameter OPERAND_W, default 11, operand field width; the instruction word is OPCODE_W+OPERAND_W bits, opcode in the MSBs.
REQ-004 Parameter PC_W, default 11, program counter width.
REQ-005 Parameter DMEM_DEPTH, default 1024, internal data memory words; this SHALL be a power of two.
REQ-006 Parameter COUNT_W, default 8, instruction counter width.
REQ-007 clk  input  1  single clock; all state changes on the rising edge.
REQ-008 rst  input  1  reset, synchronous, active-low.
REQ-009 en  input  1  run enable; when 0 the core stalls.
REQ-010 prog_addr  output  PC_W  program memory read address.
REQ-011 prog_data  input  OPCODE_W+OPERAND_W  instruction word, valid one cycle after prog_addr (synchronous ROM).
REQ-012 accumulator  output  DATA_W  current accumulator value.
REQ-013 inst_count  output  COUNT_W  count of retired non-HLT instructions.
REQ-014 done  output  1  high once HLT is executed.

Function
REQ-015 The FSM SHALL have three states, FETCH, EXEC and HALT; reset enters FETCH.
REQ-016 In FETCH with en=1: drive prog_addr=pc; next state EXEC.
REQ-017 In EXEC with en=1: decode prog_data, update the accumulator, memory, pc and inst_count per REQ-018..REQ-021; next state FETCH, or HALT for HLT.
REQ-018 Opcodes: 0 HLT; 1 STO mem[op]<=acc; 2 LD acc<=mem[op]; 3 LDI acc<=imm; 4 ADD acc<=acc+mem[op]; 5 ADDI acc<=acc+imm; 6 SUB acc<=acc-mem[op]; 7 SUBI acc<=acc-imm; 8..max NOP.
REQ-019 imm SHALL be the operand sign-extended to DATA_W, or truncated to its low DATA_W bits if OPERAND_W>DATA_W; arithmetic wraps modulo 2^DATA_W.
REQ-020 The data-memory index SHALL be the low log2(DMEM_DEPTH) operand bits; reads are combinational within EXEC; STO writes at the EXEC clock edge.
REQ-021 For every non-HLT opcode, including NOPs, pc increments by 1, wrapping from 2^PC_W-1 to 0, and inst_count increments by 1, wrapping to 0.
REQ-022 HLT SHALL leave acc, pc, memory and inst_count unchanged, and the core SHALL set done=1 one cycle after the EXEC edge.
REQ-023 HALT SHALL be absorbing until reset; en is ignored and no state changes.
REQ-024 When en=0 in FETCH or EXEC, all state, outputs and prog_addr SHALL hold; when en returns to 1, EXEC SHALL use the prog_data that is current at that edge, because the ROM output is stable while its address is held.
REQ-025 Each instruction SHALL take exactly 2 enabled cycles; the accumulator updates at the end of EXEC.

Reset
REQ-026 rst=0 at a rising edge SHALL force FETCH, pc=0, accumulator=0, inst_count=0 and done=0, with prog_addr=0 on the next cycle, overriding en and any in-flight instruction.
REQ-027 Data memory contents SHALL NOT be cleared by reset.

Configuration
REQ-028 With BIP_OVERFLOW_FLAG_EN defined, the core SHALL add the output port overflow (1 bit).
REQ-029 overflow SHALL be sticky and set on signed two's-complement overflow of ADD/ADDI/SUB/SUBI, and cleared only by reset.
REQ-030 Without BIP_OVERFLOW_FLAG_EN, the port and its logic SHALL be absent and all other behaviour is identical.

Verification
REQ-031 Program LDI 5, ADDI 3, STO 0, SUBI 10, ADD 0, HLT with en=1 -> accumulator 5, 8, 8, 0xFFFE, 0x0006; done=1 at cycle 12 after reset release; inst_count=5.
REQ-032 Same program with en=0 for 3 cycles at each EXEC -> identical final results, and done is delayed by 15 cycles.
REQ-033 Assert rst=0 in the EXEC of ADDI 3 -> the next cycle shows accumulator=0, inst_count=0, prog_addr=0 and done=0; the rerun then matches REQ-031.
REQ-034 Run 256 NOPs then HLT with COUNT_W=8 -> inst_count=0 (wrapped), pc=256, done=1.
REQ-035 With BIP_OVERFLOW_FLAG_EN defined: LDI 1023, STO 1, LD 1 repeated, then ADD 1 until the accumulator exceeds 0x7FFF -> overflow rises on the crossing instruction and stays 1 after a later SUBI 1.
REQ-036 After HLT, toggle en and drive prog_data with random values for 20 cycles -> all outputs remain unchanged.
